cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the ARM-subset CPU. It owns the PC and sequences fetch, decode, execute and memory access around the instruction decoder, register file and memory ports. It drives the decoder enable, the memory request handshakes and the register-file, link-register and base-writeback strobes. It also counts retired instructions and flags bus timeouts.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/cpu_sequencer_if.sv | 53 +++++
 rtl/cpu_sequencer_wait_timer.sv | 29 ++
 rtl/cpu_sequencer.sv | 120 ++++++++++++
 tb/tb_cpu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the ARM-subset control path.
// State values also appear on the debug state port.
package cpu_ctrl_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] MEM    = 3'd4;
   localparam logic [2:0] FAULT  = 3'd7;

   localparam logic [31:0] PC_INCR = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = IDLE,
      ST_FETCH  = FETCH,
      ST_DECODE = DECODE,
      ST_EXEC   = EXEC,
      ST_MEM    = MEM,
      ST_FAULT  = FAULT
   } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory handshakes, decoder fields and
// register-file strobes between the sequencer and the datapath.
interface cpu_sequencer_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        ir_load;
   logic        decode_en;
   logic        dec_valid;
   logic        cond_pass;
   logic        is_branch;
   logic        branch_with_link;
   logic [31:0] branch_target;
   logic        mem_read;
   logic        mem_write;
   logic        is_not_postindex;
   logic        is_write_back;
   logic        exec_en;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;
   logic        rf_we;
   logic        lr_we;
   logic        base_we;

   modport master (
      output imem_req, imem_addr, ir_load,
      output decode_en, exec_en,
      output dmem_req, dmem_we,
      output rf_we, lr_we, base_we,
      input  imem_ready, dmem_ready,
      input  dec_valid, cond_pass,
      input  is_branch, branch_with_link,
      input  branch_target,
      input  mem_read, mem_write,
      input  is_not_postindex, is_write_back
   );

   modport slave (
      input  imem_req, imem_addr, ir_load,
      input  decode_en, exec_en,
      input  dmem_req, dmem_we,
      input  rf_we, lr_we, base_we,
      output imem_ready, dmem_ready,
      output dec_valid, cond_pass,
      output is_branch, branch_with_link,
      output branch_target,
      output mem_read, mem_write,
      output is_not_postindex, is_write_back
   );

endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// wait_timer: saturating wait counter shared by fetch and data access.
// expired flags the last waiting cycle before the limit; LIMIT=0 disables.
module wait_timer #(
   parameter int unsigned LIMIT = 255,
   parameter int unsigned W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (LIMIT != 0) && en &&
                    (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem control FSM.
// Owns the PC, the retire counter and the sticky bus-fault flag.
module cpu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TMO_W       = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           run,
   cpu_sequencer_if.master bus,
   output logic [31:0]    pc,
   output logic [31:0]    retired,
   output logic           fault,
   output logic [2:0]     state
);

   state_t      st;
   logic        in_fetch, in_dec, in_exec, in_mem;
   logic        go, both, any_mem;
   logic        waiting, ready, tmo;
   logic        take_br, retire;
   logic [31:0] pc_next;

   assign in_fetch = (st == ST_FETCH);
   assign in_dec   = (st == ST_DECODE);
   assign in_exec  = (st == ST_EXEC);
   assign in_mem   = (st == ST_MEM);

   assign go      = bus.dec_valid & bus.cond_pass;
   assign both    = bus.mem_read & bus.mem_write;
   assign any_mem = bus.mem_read | bus.mem_write;

   assign waiting = in_fetch | in_mem;
   assign ready   = in_fetch ? bus.imem_ready
                             : bus.dmem_ready;

   wait_timer #(
      .LIMIT (MEM_TIMEOUT),
      .W     (TMO_W)
   ) u_tmr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (~waiting | ready),
      .en      (waiting & ~ready),
      .expired (tmo)
   );

   // Branches take priority over memory flags once condition passes.
   assign take_br = in_exec & go & ~both & bus.is_branch;

   assign retire = (in_exec & (~go | (~both &
                   (bus.is_branch | ~any_mem)))) |
                   (in_mem & bus.dmem_ready);

   assign pc_next = take_br ? bus.branch_target
                            : pc + PC_INCR;

   assign bus.imem_req  = in_fetch;
   assign bus.imem_addr = pc;
   assign bus.ir_load   = in_fetch & bus.imem_ready;
   assign bus.decode_en = in_dec;
   assign bus.exec_en   = in_exec;
   assign bus.dmem_req  = in_mem;
   assign bus.dmem_we   = in_mem & bus.mem_write;

   assign bus.rf_we =
      (in_exec & go & ~both & ~bus.is_branch & ~any_mem) |
      (in_mem & bus.dmem_ready & bus.mem_read);
   assign bus.lr_we   = take_br & bus.branch_with_link;
   assign bus.base_we = in_mem & bus.dmem_ready &
      (bus.is_write_back | ~bus.is_not_postindex);

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         pc      <= RESET_PC;
         retired <= '0;
         fault   <= 1'b0;
      end else begin
         unique case (st)
            ST_IDLE: begin
               if (run) st <= ST_FETCH;
            end
            ST_FETCH: begin
               if (bus.imem_ready) begin
                  st <= ST_DECODE;
               end else if (tmo) begin
                  st    <= ST_FAULT;
                  fault <= 1'b1;
               end
            end
            ST_DECODE: st <= ST_EXEC;
            ST_EXEC, ST_MEM: begin
               if (retire) begin
                  pc      <= pc_next;
                  retired <= retired + 32'd1;
                  st      <= run ? ST_FETCH : ST_IDLE;
               end else if ((in_exec & both) |
                            (in_mem & tmo)) begin
                  st    <= ST_FAULT;
                  fault <= 1'b1;
               end else if (in_exec) begin
                  st <= ST_MEM;
               end
            end
            ST_FAULT: st <= ST_FAULT;
            default: begin
               st    <= ST_FAULT;
               fault <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized driver plus scoreboard monitor
// checking retire results, fetch addresses and fault/reset behaviour.
module tb_cpu_sequencer;
   import cpu_ctrl_pkg::*;

   localparam int N = 60;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [31:0] pc, retired;
   logic        fault;
   logic [2:0]  state;

   cpu_sequencer_if bus ();

   cpu_sequencer #(
      .RESET_PC    (32'h0),
      .MEM_TIMEOUT (4),
      .TMO_W       (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .bus     (bus),
      .pc      (pc),
      .retired (retired),
      .fault   (fault),
      .state   (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ret;
      logic [63:0] st;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] fq[$];
   int          checks = 0;
   int          passes = 0;
   bit          mon_en = 1'b0;
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_ret = 32'h0;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h expected %h",
                    nm, got, exp);
   endtask

   task automatic fetch_one(input int iw,
                            input logic [31:0] addr);
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.imem_req)
         chk("fetch_wait", 64'(bus.imem_req), 64'(1));
      repeat (iw) @(negedge clk);
      bus.imem_ready = 1'b1;
      fq.push_back(addr);
      @(negedge clk);
      bus.imem_ready = 1'b0;
   endtask

   task automatic set_dec(input logic v, cp, br, bl,
                          input logic rd, wr, p, wb,
                          input logic [31:0] tgt);
      bus.dec_valid        = v;
      bus.cond_pass        = cp;
      bus.is_branch        = br;
      bus.branch_with_link = bl;
      bus.mem_read         = rd;
      bus.mem_write        = wr;
      bus.is_not_postindex = p;
      bus.is_write_back    = wb;
      bus.branch_target    = tgt;
   endtask

   task automatic issue(input logic v, cp, br, bl,
                        input logic rd, wr, p, wb,
                        input logic [31:0] tgt,
                        input int iw, dw,
                        input bit last);
      exp_t e;
      logic [7:0] rf, lr, bs, dwe, drq;
      int cyc;
      bit mem;
      rf = 0; lr = 0; bs = 0; dwe = 0; drq = 0;
      mem = 0;
      cyc = iw + 3;
      fetch_one(iw, m_pc);
      if (last) run = 1'b0;
      set_dec(v, cp, br, bl, rd, wr, p, wb, tgt);
      if (!(v && cp)) begin
         m_pc += 32'd4;
      end else if (br) begin
         m_pc = tgt;
         lr = 8'(bl);
      end else if (rd || wr) begin
         mem = 1;
         rf  = 8'(rd);
         bs  = 8'(wb || !p);
         drq = 8'(dw + 1);
         dwe = wr ? 8'(dw + 1) : 8'd0;
         cyc += dw + 1;
         m_pc += 32'd4;
      end else begin
         rf = 8'd1;
         m_pc += 32'd4;
      end
      m_ret += 32'd1;
      e.pc  = m_pc;
      e.ret = m_ret;
      e.st  = {rf, lr, bs, dwe, drq,
               8'd1, 8'd1, 8'(cyc)};
      sb.push_back(e);
      @(negedge clk);
      if (mem) begin
         @(negedge clk);
         repeat (dw) @(negedge clk);
         bus.dmem_ready = 1'b1;
         @(negedge clk);
         bus.dmem_ready = 1'b0;
      end
   endtask

   initial begin : monitor
      exp_t        e;
      logic [31:0] last_ret, fa;
      logic [7:0]  a[8];
      last_ret = '0;
      foreach (a[i]) a[i] = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!mon_en || !rst_n) begin
            last_ret = retired;
            foreach (a[i]) a[i] = '0;
            continue;
         end
         if (retired !== last_ret) begin
            last_ret = retired;
            if (sb.size() == 0) begin
               chk("unexpected_retire",
                   64'(sb.size()), 64'(1));
            end else begin
               e = sb.pop_front();
               chk("pc", 64'(pc), 64'(e.pc));
               chk("retired", 64'(retired), 64'(e.ret));
               chk("strobes",
                   {a[0], a[1], a[2], a[3],
                    a[4], a[5], a[6], a[7]}, e.st);
            end
            foreach (a[i]) a[i] = '0;
         end
         if (bus.imem_req && bus.imem_ready) begin
            fa = (fq.size() > 0) ? fq.pop_front()
                                 : ~bus.imem_addr;
            chk("fetch",
                64'({bus.ir_load, bus.imem_addr}),
                64'({1'b1, fa}));
         end
         a[0] += 8'(bus.rf_we);
         a[1] += 8'(bus.lr_we);
         a[2] += 8'(bus.base_we);
         a[3] += 8'(bus.dmem_we);
         a[4] += 8'(bus.dmem_req);
         a[5] += 8'(bus.decode_en);
         a[6] += 8'(bus.exec_en);
         a[7] += 8'(state != 3'd0);
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic v, cp, br, bl, rd, wr, p, wb;
      logic [31:0] tgt;
      int iw, dw, k, n;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      run = 1'b1;
      #12;
      chk("rst_outputs",
          64'({state, fault, bus.imem_req,
               bus.dmem_req, bus.rf_we}), 64'(0));
      chk("rst_pc", 64'(pc), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < N; i++) begin
         v = 1; cp = 1; br = 0; bl = 0;
         rd = 0; wr = 0; p = 1; wb = 0;
         tgt = 32'h0; iw = 0; dw = 0;
         case (i)
            0: ;
            1: begin br = 1; bl = 1; tgt = 32'h100; end
            2: begin rd = 1; p = 0; wb = 0; dw = 3; end
            3: begin wr = 1; cp = 0; end
            4: begin br = 1; tgt = 32'hFFFF_FFFC; end
            5: ;
            6: begin v = 0; rd = 1; wr = 1; end
            default: begin
               v  = ($urandom_range(0, 9) != 0);
               cp = ($urandom_range(0, 4) != 0);
               br = ($urandom_range(0, 3) == 0);
               bl = 1'($urandom_range(0, 1));
               p  = 1'($urandom_range(0, 1));
               wb = 1'($urandom_range(0, 1));
               k  = int'($urandom_range(0, 2));
               rd = (k == 1);
               wr = (k == 2);
               if (!(v && cp) &&
                   $urandom_range(0, 3) == 0) begin
                  rd = 1; wr = 1;
               end
               tgt = $urandom();
               iw  = int'($urandom_range(0, 3));
               dw  = int'($urandom_range(0, 3));
            end
         endcase
         issue(v, cp, br, bl, rd, wr, p, wb,
               tgt, iw, dw, i == N - 1);
      end

      for (int j = 0; j < 20 && sb.size() > 0; j++)
         @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'(0));
      @(negedge clk);
      #2;
      chk("idle_after_run_low",
          64'({state, bus.imem_req}), 64'(0));
      mon_en = 1'b0;

      run = 1'b1;
      fetch_one(0, m_pc);
      set_dec(1, 1, 0, 0, 1, 1, 1, 0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("dual_flag_fault",
          64'({state, fault}), 64'({3'd7, 1'b1}));
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_fault",
          64'({state, fault, pc}), 64'(0));
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      n = 0;
      for (int j = 0; j < 20 && state != 3'd7; j++) begin
         @(negedge clk);
         #2;
         if (bus.imem_req) n++;
      end
      chk("tmo_cycles", 64'(n), 64'(4));
      chk("tmo_fault",
          64'({state, fault, bus.imem_req}),
          64'({3'd7, 1'b1, 1'b0}));
      bus.imem_ready = 1'b1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      #2;
      chk("tmo_sticky",
          64'({state, fault, pc}),
          64'({3'd7, 1'b1, 32'h0}));

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      fetch_one(0, 32'h0);
      set_dec(1, 1, 0, 0, 0, 0, 1, 0, 32'h0);
      @(negedge clk);
      fetch_one(0, 32'h4);
      set_dec(1, 1, 0, 0, 1, 0, 1, 1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("mem_wait",
          64'({bus.dmem_req, pc, retired[7:0]}),
          64'({1'b1, 32'h4, 8'd1}));
      #1;
      rst_n = 1'b0;
      run   = 1'b0;
      #1;
      chk("rst_mid_mem",
          64'({bus.dmem_req, state, pc, retired[7:0]}),
          64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.dmem_ready = 1'b1;
      @(negedge clk);
      bus.dmem_ready = 1'b0;
      #2;
      chk("ready_ignored",
          64'({state, bus.dmem_req, bus.rf_we,
               pc, retired[7:0]}), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
